// File: rtl/wb_bus_arbiter_2m.sv
// wb_bus_arbiter_2m: two-master / one-slave Wishbone arbiter.
// Master 0 is the control unit and master 1 is the debug/host bridge.
// Round-robin arbitration on simultaneous requests, lock hold, and a
// watchdog that answers a stalled access with err instead of hanging.
module wb_bus_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RESET_LAST     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_lock_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_lock_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_lock_o,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT0  = 2'd1,
        S_GNT1  = 2'd2,
        S_TOERR = 2'd3
    } state_t;

    // Watchdog count value on the last stalled cycle before err is forced
    localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_gnt;
    logic        r_timeout;
    logic [15:0] r_wdog;
    logic        r_last;

    logic        w_sel0;
    logic        w_sel1;
    logic        w_term;
    logic        w_own_cyc;
    logic        w_own_lock;
    logic        w_expire;

    assign w_sel0     = (r_state == S_GNT0);
    assign w_sel1     = (r_state == S_GNT1);
    assign w_term     = s_ack_i | s_err_i | s_rty_i;
    assign w_own_cyc  = w_sel1 ? m1_cyc_i  : m0_cyc_i;
    assign w_own_lock = w_sel1 ? m1_lock_i : m0_lock_i;
    assign w_expire   = (w_sel0 | w_sel1) & s_stb_o & ~w_term & (r_wdog == LP_WD_LAST);

    // Slave port carries the owning master's request; bus is idle otherwise
    always_comb begin
        s_addr_o = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_lock_o = 1'b0;
        if (w_sel0) begin
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_lock_o = m0_lock_i;
        end else if (w_sel1) begin
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_lock_o = m1_lock_i;
        end
    end

    // Slave responses reach only the owner. r_timeout is high exactly in
    // TOERR, where r_last already names the master whose access timed out,
    // so late slave terminations in TOERR/IDLE are never forwarded.
    assign m0_ack_o = w_sel0 & s_ack_i;
    assign m0_rty_o = w_sel0 & s_rty_i;
    assign m0_err_o = (w_sel0 & s_err_i) | (r_timeout & ~r_last);
    assign m0_dat_o = w_sel0 ? s_dat_i : '0;

    assign m1_ack_o = w_sel1 & s_ack_i;
    assign m1_rty_o = w_sel1 & s_rty_i;
    assign m1_err_o = (w_sel1 & s_err_i) | (r_timeout & r_last);
    assign m1_dat_o = w_sel1 ? s_dat_i : '0;

    assign gnt_o     = r_gnt;
    assign timeout_o = r_timeout;

    // Arbitration FSM with registered grant/timeout outputs and watchdog
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_timeout <= 1'b0;
            r_wdog    <= '0;
            r_last    <= RESET_LAST;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (r_last) begin
                            r_state <= S_GNT0;
                            r_gnt   <= 2'b01;
                        end else begin
                            r_state <= S_GNT1;
                            r_gnt   <= 2'b10;
                        end
                    end else if (m0_cyc_i) begin
                        r_state <= S_GNT0;
                        r_gnt   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        r_state <= S_GNT1;
                        r_gnt   <= 2'b10;
                    end
                end

                S_GNT0, S_GNT1: begin
                    if (!w_own_cyc && !w_own_lock) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_last  <= w_sel1;
                        r_wdog  <= '0;
                    end else if (w_expire) begin
                        r_state   <= S_TOERR;
                        r_gnt     <= '0;
                        r_timeout <= 1'b1;
                        r_last    <= w_sel1;
                        r_wdog    <= '0;
                    end else if (w_term) begin
                        r_wdog <= '0;
                    end else if (s_stb_o) begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end

                S_TOERR: begin
                    r_state <= S_IDLE;
                    r_wdog  <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_wdog  <= '0;
                end
            endcase
        end
    end

endmodule
